operand_sequencer: RTL and testbench
====================================

Name: operand_sequencer

Overview:
- Control FSM between the board peripherals (enter pulse, 8-bit switches, load switch) and the arithmetic unit.
- Assembles operands A and B byte by byte, least-significant byte first, from user entries.
- Issues a one-cycle start to the unit, waits for done with a timeout, and latches the 32-bit result.
- Pages the result onto a 16-bit display bus feeding the four hex 7-segment decoders.

Parameters:
- BYTES_PER_OPERAND, 4, bytes per operand; operand width is 8*BYTES_PER_OPERAND.
- TIMEOUT_CYCLES, 1024, maximum cycles spent in WAIT before ERROR; must be >= 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enterpulse  in  1  single-cycle pulse from the enter-button pulse generator
- loaddata  in  1  load-enable switch; entries are ignored while low
- inputdata  in  8  switch byte
- dataA  out  32  assembled operand A
- dataB  out  32  assembled operand B
- start  out  1  one-cycle start pulse to the arithmetic unit
- done  in  1  unit completion; honoured only in WAIT
- dataR  in  32  unit result; valid in the cycle done is high
- inputdata_ready  out  1  level: both operands are complete
- busy  out  1  high in START and WAIT
- error  out  1  high in ERROR
- display_value  out  16  four hex nibbles for the 7-seg decoders

Behaviour:
- Clock and reset: clk and reset only. reset is synchronous and active-high; it overrides everything, including mid-entry and mid-WAIT.
- Reset values: state=LOAD_A, byte_idx=0, dataA=0, dataB=0, result_q=0, timeout count=0, start=0, inputdata_ready=0, busy=0, error=0, display_value=16'h0000.
- A byte is "accepted" on a clock edge where enterpulse && loaddata is high in a LOAD state.
  - The byte is written to operand[byte_idx*8 +: 8] and is visible the next cycle.
  - byte_idx increments on each accept.
- LOAD_A: on accepting byte BYTES_PER_OPERAND-1, go to LOAD_B with byte_idx=0. enterpulse while loaddata=0 has no effect.
- LOAD_B: same accept rule into dataB. After the last byte, go to START. inputdata_ready rises on that same edge.
- START: lasts exactly 1 cycle with start=1, then goes to WAIT. done in START is ignored (unit latency >= 1 cycle).
- WAIT: the counter increments each cycle.
  - If done=1: result_q<=dataR, go to SHOW_LO, clear the counter.
  - Else if count==TIMEOUT_CYCLES-1: go to ERROR.
  - done on the timeout cycle wins over the timeout.
  - enterpulse is ignored in WAIT.
- SHOW_LO: enterpulse goes to SHOW_HI.
- SHOW_HI: enterpulse goes to LOAD_A. On that edge dataA, dataB and byte_idx are cleared and inputdata_ready falls.
- ERROR: enterpulse goes to LOAD_A with the same clearing as above. result_q is unchanged.
- loaddata has no effect outside the LOAD states.
- inputdata_ready is high in START, WAIT, SHOW_LO, SHOW_HI and ERROR.
- display_value (registered, 1-cycle latency from the state/data change):
  - LOAD_A: {4'hA, 2'b00, byte_idx[1:0], inputdata}
  - LOAD_B: {4'hB, 2'b00, byte_idx[1:0], inputdata}
  - START or WAIT: 16'hBBBB
  - SHOW_LO: result_q[15:0]
  - SHOW_HI: result_q[31:16]
  - ERROR: 16'hEEEE
- byte_idx width is clog2(BYTES_PER_OPERAND). It never wraps inside an operand because state changes at the last index.
- Timeout counter width is clog2(TIMEOUT_CYCLES).

Decomposition:
- Package seq_pkg:
  - state enum (LOAD_A, LOAD_B, START, WAIT, SHOW_LO, SHOW_HI, ERROR), 3-bit encoding
  - display constants DISP_BUSY=16'hBBBB, DISP_ERR=16'hEEEE, TAG_A=4'hA, TAG_B=4'hB
- One sub-module, seq_timeout_counter: clear, enable, count, expired at TIMEOUT_CYCLES-1.
- Operand assembly and display mux stay in the top module.

Test Plan:
- Reset, then enter 0x78,0x56,0x34,0x12 for A and 0xEF,0xBE,0xAD,0xDE for B, loaddata=1 -> dataA=32'h12345678, dataB=32'hDEADBEEF; start is high exactly 1 cycle after the 8th pulse; inputdata_ready rises on the same edge.
- In LOAD_A, 3 pulses with loaddata=0, then 1 with loaddata=1 and inputdata=0x5A -> only byte0=0x5A; display_value=16'hA15A after settling (byte_idx=1, switches still 0x5A).
- Unit model asserts done 5 cycles after start with dataR=32'hCAFEF00D -> display 16'hF00D, pulse -> 16'hCAFE, pulse -> LOAD_A with dataA=dataB=0 and inputdata_ready=0.
- TIMEOUT_CYCLES=16, done never asserted -> ERROR after 16 WAIT cycles; display 16'hEEEE; error=1; a pulse returns to LOAD_A.
- done asserted exactly on the timeout cycle -> SHOW_LO, not ERROR; error stays 0.
- reset asserted in WAIT and in LOAD_B after 2 bytes -> next cycle all outputs at reset values, state LOAD_A; a late done after reset is ignored.

Source files
------------

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and constants for the operand sequencer
//
// Purpose: FSM state encoding and the fixed display codes used by
// operand_sequencer and its helpers.
// Ports: none (package).

package seq_pkg;

   typedef enum logic [2:0] {
      LOAD_A  = 3'd0,
      LOAD_B  = 3'd1,
      START   = 3'd2,
      WAIT    = 3'd3,
      SHOW_LO = 3'd4,
      SHOW_HI = 3'd5,
      ERROR   = 3'd6
   } seq_state_t;

   localparam logic [15:0] DISP_BUSY = 16'hBBBB;
   localparam logic [15:0] DISP_ERR  = 16'hEEEE;
   localparam logic [3:0]  TAG_A     = 4'hA;
   localparam logic [3:0]  TAG_B     = 4'hB;

endpackage

// File: rtl/seq_timeout_counter.sv
// rtl/seq_timeout_counter.sv - cycle counter flagging the last allowed WAIT cycle
//
// Purpose: counts enabled cycles from zero; expired is high while the count
// sits at TIMEOUT_CYCLES-1, so the owner can leave on that same edge.
// Ports:
//   clk     in  system clock
//   reset   in  synchronous, active-high reset
//   clear   in  synchronous clear (wins over enable)
//   enable  in  count this cycle
//   expired out count == TIMEOUT_CYCLES-1

module seq_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CW'(1);
      end
   end

   assign expired = (count == LAST);

endmodule

// File: rtl/operand_sequencer.sv
// rtl/operand_sequencer.sv - operand entry, unit handshake and result paging FSM
//
// Purpose: assembles operands A and B byte by byte (LSB first) from switch
// entries, pulses start to the arithmetic unit, waits for done with a
// timeout, latches the result and pages it onto the 7-segment display bus.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   enterpulse        one-cycle enter button pulse
//   loaddata          load-enable switch, gates entries in LOAD states
//   inputdata[7:0]    switch byte
//   dataA, dataB      assembled operands
//   start             one-cycle start pulse to the unit
//   done, dataR       unit completion and result (honoured only in WAIT)
//   inputdata_ready   both operands complete
//   busy              START or WAIT
//   error             timeout occurred (ERROR state)
//   display_value     four hex nibbles for the display decoders (registered)

module operand_sequencer
   import seq_pkg::*;
#(
   parameter int BYTES_PER_OPERAND = 4,
   parameter int TIMEOUT_CYCLES    = 1024
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           enterpulse,
   input  logic                           loaddata,
   input  logic [7:0]                     inputdata,
   output logic [8*BYTES_PER_OPERAND-1:0] dataA,
   output logic [8*BYTES_PER_OPERAND-1:0] dataB,
   output logic                           start,
   input  logic                           done,
   input  logic [31:0]                    dataR,
   output logic                           inputdata_ready,
   output logic                           busy,
   output logic                           error,
   output logic [15:0]                    display_value
);

   // A one-byte operand still needs a 1-bit index register.
   localparam int IW = (BYTES_PER_OPERAND > 1) ? $clog2(BYTES_PER_OPERAND) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(BYTES_PER_OPERAND - 1);

   seq_state_t    state, state_n;
   logic [IW-1:0] byte_idx;
   logic [31:0]   result_q;
   logic [15:0]   disp_n;
   logic [1:0]    idx_disp;
   logic          accept;
   logic          last_byte;
   logic          timeout_expired;
   logic          clear_entry;

   assign accept      = enterpulse && loaddata;
   assign last_byte   = (byte_idx == LAST_IDX);
   assign idx_disp    = 2'(byte_idx);
   // Leaving SHOW_HI or ERROR starts a fresh entry from scratch.
   assign clear_entry = enterpulse && ((state == SHOW_HI) || (state == ERROR));

   seq_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  ((state != WAIT) || done),
      .enable (state == WAIT),
      .expired(timeout_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= LOAD_A;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n         = state;
      start           = 1'b0;
      busy            = 1'b0;
      error           = 1'b0;
      inputdata_ready = 1'b0;
      disp_n          = 16'h0000;
      case (state)
         LOAD_A: begin
            disp_n = {TAG_A, 2'b00, idx_disp, inputdata};
            if (accept && last_byte) state_n = LOAD_B;
         end
         LOAD_B: begin
            disp_n = {TAG_B, 2'b00, idx_disp, inputdata};
            if (accept && last_byte) state_n = START;
         end
         START: begin
            start           = 1'b1;
            busy            = 1'b1;
            inputdata_ready = 1'b1;
            disp_n          = DISP_BUSY;
            state_n         = WAIT;
         end
         WAIT: begin
            busy            = 1'b1;
            inputdata_ready = 1'b1;
            disp_n          = DISP_BUSY;
            // done on the final allowed cycle still counts as success.
            if (done) begin
               state_n = SHOW_LO;
            end else if (timeout_expired) begin
               state_n = ERROR;
            end
         end
         SHOW_LO: begin
            inputdata_ready = 1'b1;
            disp_n          = result_q[15:0];
            if (enterpulse) state_n = SHOW_HI;
         end
         SHOW_HI: begin
            inputdata_ready = 1'b1;
            disp_n          = result_q[31:16];
            if (enterpulse) state_n = LOAD_A;
         end
         ERROR: begin
            error           = 1'b1;
            inputdata_ready = 1'b1;
            disp_n          = DISP_ERR;
            if (enterpulse) state_n = LOAD_A;
         end
         default: state_n = LOAD_A;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         byte_idx      <= '0;
         dataA         <= '0;
         dataB         <= '0;
         result_q      <= '0;
         display_value <= 16'h0000;
      end else begin
         display_value <= disp_n;
         if (clear_entry) begin
            byte_idx <= '0;
            dataA    <= '0;
            dataB    <= '0;
         end else if (accept && (state == LOAD_A || state == LOAD_B)) begin
            if (state == LOAD_A) begin
               dataA[{byte_idx, 3'b000} +: 8] <= inputdata;
            end else begin
               dataB[{byte_idx, 3'b000} +: 8] <= inputdata;
            end
            // Wrap to 0 at the last byte so LOAD_B starts at byte 0.
            byte_idx <= last_byte ? '0 : byte_idx + IW'(1);
         end
         if (state == WAIT && done) begin
            result_q <= dataR;
         end
      end
   end

endmodule

// File: tb/tb_operand_sequencer.sv
// tb/tb_operand_sequencer.sv - self-checking bench for operand_sequencer

module tb_operand_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        enterpulse;
   logic        loaddata;
   logic [7:0]  inputdata;
   logic [31:0] dataA;
   logic [31:0] dataB;
   logic        start;
   logic        done;
   logic [31:0] dataR;
   logic        inputdata_ready;
   logic        busy;
   logic        error;
   logic [15:0] display_value;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_ops[$];
   logic [15:0] exp_pages[$];

   operand_sequencer #(
      .BYTES_PER_OPERAND(4),
      .TIMEOUT_CYCLES   (16)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .enterpulse     (enterpulse),
      .loaddata       (loaddata),
      .inputdata      (inputdata),
      .dataA          (dataA),
      .dataB          (dataB),
      .start          (start),
      .done           (done),
      .dataR          (dataR),
      .inputdata_ready(inputdata_ready),
      .busy           (busy),
      .error          (error),
      .display_value  (display_value)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic pulse(input logic [7:0] b, input logic ld);
      inputdata  = b;
      loaddata   = ld;
      enterpulse = 1'b1;
      @(negedge clk);
      enterpulse = 1'b0;
   endtask

   task automatic load_pair(input logic [31:0] a, input logic [31:0] b);
      for (int i = 0; i < 4; i++) pulse(a[i*8 +: 8], 1'b1);
      for (int i = 0; i < 4; i++) pulse(b[i*8 +: 8], 1'b1);
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      enterpulse = 1'b1;
      loaddata   = 1'b1;
      inputdata  = 8'hFF;
      repeat (2) step();
      reset      = 1'b0;
      enterpulse = 1'b0;
      loaddata   = 1'b0;
      checks++; if (dataA !== 32'h0) begin errors++; $display("FAIL rst_dataA: got %h expected %h", dataA, 32'h0); end
      checks++; if (dataB !== 32'h0) begin errors++; $display("FAIL rst_dataB: got %h expected %h", dataB, 32'h0); end
      checks++; if (start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b expected 0", start); end
      checks++; if (inputdata_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", inputdata_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error: got %b expected 0", error); end
      checks++; if (display_value !== 16'h0000) begin errors++; $display("FAIL rst_display: got %h expected 0000", display_value); end
   endtask

   task automatic test_load_and_compute();
      logic [31:0] a = 32'h12345678;
      logic [31:0] b = 32'hDEADBEEF;
      logic [31:0] exp_word;
      logic [15:0] exp_page;
      exp_ops.push_back(a);
      exp_ops.push_back(b);
      for (int i = 0; i < 4; i++) pulse(a[i*8 +: 8], 1'b1);
      for (int i = 0; i < 3; i++) pulse(b[i*8 +: 8], 1'b1);
      checks++; if (inputdata_ready !== 1'b0) begin errors++; $display("FAIL ready_before_last: got %b expected 0", inputdata_ready); end
      checks++; if (start !== 1'b0) begin errors++; $display("FAIL start_before_last: got %b expected 0", start); end
      pulse(b[31:24], 1'b1);
      checks++; if (start !== 1'b1) begin errors++; $display("FAIL start_after_last: got %b expected 1", start); end
      checks++; if (inputdata_ready !== 1'b1) begin errors++; $display("FAIL ready_after_last: got %b expected 1", inputdata_ready); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_start: got %b expected 1", busy); end
      exp_word = exp_ops.pop_front();
      checks++; if (dataA !== exp_word) begin errors++; $display("FAIL dataA: got %h expected %h", dataA, exp_word); end
      exp_word = exp_ops.pop_front();
      checks++; if (dataB !== exp_word) begin errors++; $display("FAIL dataB: got %h expected %h", dataB, exp_word); end
      step();
      checks++; if (start !== 1'b0) begin errors++; $display("FAIL start_one_cycle: got %b expected 0", start); end
      checks++; if (display_value !== 16'hBBBB) begin errors++; $display("FAIL disp_busy: got %h expected BBBB", display_value); end
      repeat (4) step();
      dataR = 32'hCAFEF00D;
      done  = 1'b1;
      exp_pages.push_back(16'hF00D);
      exp_pages.push_back(16'hCAFE);
      step();
      done  = 1'b0;
      dataR = 32'h0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_show: got %b expected 0", busy); end
      step();
      exp_page = exp_pages.pop_front();
      checks++; if (display_value !== exp_page) begin errors++; $display("FAIL page_lo: got %h expected %h", display_value, exp_page); end
      pulse(8'h00, 1'b0);
      step();
      exp_page = exp_pages.pop_front();
      checks++; if (display_value !== exp_page) begin errors++; $display("FAIL page_hi: got %h expected %h", display_value, exp_page); end
      pulse(8'h00, 1'b0);
      checks++; if (dataA !== 32'h0) begin errors++; $display("FAIL clr_dataA: got %h expected 0", dataA); end
      checks++; if (dataB !== 32'h0) begin errors++; $display("FAIL clr_dataB: got %h expected 0", dataB); end
      checks++; if (inputdata_ready !== 1'b0) begin errors++; $display("FAIL clr_ready: got %b expected 0", inputdata_ready); end
   endtask

   task automatic test_loaddata_gate();
      pulse(8'h11, 1'b0);
      pulse(8'h22, 1'b0);
      pulse(8'h33, 1'b0);
      pulse(8'h5A, 1'b1);
      checks++; if (dataA !== 32'h0000005A) begin errors++; $display("FAIL gate_dataA: got %h expected 0000005A", dataA); end
      step();
      checks++; if (display_value !== 16'hA15A) begin errors++; $display("FAIL gate_display: got %h expected A15A", display_value); end
   endtask

   task automatic test_reset_mid_load();
      for (int i = 0; i < 3; i++) pulse(8'h01, 1'b1);
      pulse(8'hC1, 1'b1);
      pulse(8'hC2, 1'b1);
      step();
      checks++; if (display_value !== 16'hB2C2) begin errors++; $display("FAIL loadb_display: got %h expected B2C2", display_value); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++; if (dataA !== 32'h0) begin errors++; $display("FAIL rstb_dataA: got %h expected 0", dataA); end
      checks++; if (dataB !== 32'h0) begin errors++; $display("FAIL rstb_dataB: got %h expected 0", dataB); end
      checks++; if (display_value !== 16'h0000) begin errors++; $display("FAIL rstb_display: got %h expected 0000", display_value); end
      checks++; if (inputdata_ready !== 1'b0) begin errors++; $display("FAIL rstb_ready: got %b expected 0", inputdata_ready); end
      pulse(8'h77, 1'b1);
      checks++; if (dataA !== 32'h00000077) begin errors++; $display("FAIL rstb_reentry: got %h expected 00000077", dataA); end
      checks++; if (dataB !== 32'h0) begin errors++; $display("FAIL rstb_reentry_B: got %h expected 0", dataB); end
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic test_timeout();
      load_pair(32'h01020304, 32'h05060708);
      checks++; if (start !== 1'b1) begin errors++; $display("FAIL to_start: got %b expected 1", start); end
      repeat (16) step();
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL to_error_early: got %b expected 0", error); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_busy_last: got %b expected 1", busy); end
      step();
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL to_error: got %b expected 1", error); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy_err: got %b expected 0", busy); end
      step();
      checks++; if (display_value !== 16'hEEEE) begin errors++; $display("FAIL to_display: got %h expected EEEE", display_value); end
      pulse(8'h00, 1'b0);
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL to_exit_error: got %b expected 0", error); end
      checks++; if (dataA !== 32'h0) begin errors++; $display("FAIL to_exit_dataA: got %h expected 0", dataA); end
      checks++; if (inputdata_ready !== 1'b0) begin errors++; $display("FAIL to_exit_ready: got %b expected 0", inputdata_ready); end
   endtask

   task automatic test_done_on_timeout();
      logic [15:0] exp_page;
      load_pair(32'hA1A2A3A4, 32'hB1B2B3B4);
      repeat (16) step();
      dataR = 32'h13579BDF;
      done  = 1'b1;
      exp_pages.push_back(16'h9BDF);
      exp_pages.push_back(16'h1357);
      step();
      done  = 1'b0;
      dataR = 32'h0;
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL dt_error: got %b expected 0", error); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dt_busy: got %b expected 0", busy); end
      checks++; if (inputdata_ready !== 1'b1) begin errors++; $display("FAIL dt_ready: got %b expected 1", inputdata_ready); end
      step();
      exp_page = exp_pages.pop_front();
      checks++; if (display_value !== exp_page) begin errors++; $display("FAIL dt_page_lo: got %h expected %h", display_value, exp_page); end
      pulse(8'h00, 1'b0);
      step();
      exp_page = exp_pages.pop_front();
      checks++; if (display_value !== exp_page) begin errors++; $display("FAIL dt_page_hi: got %h expected %h", display_value, exp_page); end
      pulse(8'h00, 1'b0);
      checks++; if (inputdata_ready !== 1'b0) begin errors++; $display("FAIL dt_exit_ready: got %b expected 0", inputdata_ready); end
   endtask

   task automatic test_reset_in_wait();
      load_pair(32'h0BADF00D, 32'h00C0FFEE);
      repeat (3) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++; if (start !== 1'b0) begin errors++; $display("FAIL rw_start: got %b expected 0", start); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rw_busy: got %b expected 0", busy); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL rw_error: got %b expected 0", error); end
      checks++; if (inputdata_ready !== 1'b0) begin errors++; $display("FAIL rw_ready: got %b expected 0", inputdata_ready); end
      checks++; if (dataA !== 32'h0) begin errors++; $display("FAIL rw_dataA: got %h expected 0", dataA); end
      checks++; if (display_value !== 16'h0000) begin errors++; $display("FAIL rw_display: got %h expected 0000", display_value); end
      inputdata = 8'h3C;
      dataR     = 32'hFFFF1234;
      done      = 1'b1;
      step();
      done  = 1'b0;
      dataR = 32'h0;
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rw_late_busy: got %b expected 0", busy); end
      checks++; if (inputdata_ready !== 1'b0) begin errors++; $display("FAIL rw_late_ready: got %b expected 0", inputdata_ready); end
      checks++; if (display_value !== 16'hA03C) begin errors++; $display("FAIL rw_late_display: got %h expected A03C", display_value); end
   endtask

   initial begin
      reset      = 1'b1;
      enterpulse = 1'b0;
      loaddata   = 1'b0;
      inputdata  = 8'h00;
      done       = 1'b0;
      dataR      = 32'h0;
      test_reset();
      test_load_and_compute();
      test_loaddata_gate();
      test_reset_mid_load();
      test_timeout();
      test_done_on_timeout();
      test_reset_in_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
